// File: rtl/screen_pkg.sv
// Shared types and default raster timing for the screen pipeline.
// The pixel source and the timing generator both take their sizes and levels from here.
package screen_pkg;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    localparam int H_ACTIVE_DEF = 834;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 64;
    localparam int H_BP_DEF     = 80;
    localparam int V_ACTIVE_DEF = 456;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 15;

    localparam logic [7:0] BLACK_LEVEL = 8'h00;
    localparam logic [7:0] WHITE_LEVEL = 8'hFF;

    // Maps an internal active-high sync request onto the panel polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        if (active) begin
            return pol;
        end else begin
            return ~pol;
        end
    endfunction

endpackage

// File: rtl/screen_axis_cnt.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase tracker.
// Instantiated once per axis; the vertical copy steps on the horizontal wrap.
module screen_axis_cnt
    import screen_pkg::*;
#(
    parameter int ACTIVE = 834,
    parameter int FP     = 16,
    parameter int SYNC   = 64,
    parameter int BP     = 80
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       step,
    input  logic       clear,
    output logic [9:0] count,
    output phase_e     phase,
    output logic       wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    generate
        if (TOTAL > 1024 || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
            $error("screen_axis_cnt: timing parameters out of range");
        end
    endgenerate

    localparam logic [9:0] LAST_ACT  = 10'(ACTIVE - 1);
    localparam logic [9:0] LAST_FP   = 10'(ACTIVE + FP - 1);
    localparam logic [9:0] LAST_SYNC = 10'(ACTIVE + FP + SYNC - 1);
    localparam logic [9:0] LAST_TOT  = 10'(TOTAL - 1);

    logic [9:0] count_r;
    logic [9:0] count_nxt_s;
    phase_e     phase_r;
    phase_e     phase_nxt_s;

    assign wrap  = step && !clear && (count_r == LAST_TOT);
    assign count = count_r;
    assign phase = phase_r;

    // Next position and phase; clear wins over step and parks the axis at origin.
    always_comb begin
        count_nxt_s = count_r;
        phase_nxt_s = phase_r;
        if (clear) begin
            count_nxt_s = 10'd0;
            phase_nxt_s = PH_ACT;
        end else if (step) begin
            if (count_r == LAST_TOT) begin
                count_nxt_s = 10'd0;
            end else begin
                count_nxt_s = count_r + 10'd1;
            end
            case (phase_r)
                PH_ACT:  if (count_r == LAST_ACT)  phase_nxt_s = PH_FP;   else phase_nxt_s = PH_ACT;
                PH_FP:   if (count_r == LAST_FP)   phase_nxt_s = PH_SYNC; else phase_nxt_s = PH_FP;
                PH_SYNC: if (count_r == LAST_SYNC) phase_nxt_s = PH_BP;   else phase_nxt_s = PH_SYNC;
                PH_BP:   if (count_r == LAST_TOT)  phase_nxt_s = PH_ACT;  else phase_nxt_s = PH_BP;
                default: phase_nxt_s = PH_ACT;
            endcase
        end else begin
            count_nxt_s = count_r;
            phase_nxt_s = phase_r;
        end
    end

    // Axis state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= 10'd0;
            phase_r <= PH_ACT;
        end else begin
            count_r <= count_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

endmodule

// File: rtl/screen_timing_gen.sv
// Raster timing generator: lead counters issue prefetch coordinates, stage 1 drives the
// pixel source syncs, stage 2 aligns panel syncs/DE with the returned pixel.
module screen_timing_gen
    import screen_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] pix_val,
    output logic [9:0] pf_pix_row,
    output logic [9:0] pf_pix_col,
    output logic       hsync,
    output logic       vsync,
    output logic       scr_hs,
    output logic       scr_vs,
    output logic       scr_de,
    output logic [7:0] scr_pix,
    output logic       frame_start
);

    logic [9:0] h_count_s;
    logic [9:0] v_count_s;
    phase_e     h_phase_s;
    phase_e     v_phase_s;
    logic       h_wrap_s;
    logic       v_wrap_s;

    logic       de_l_s;
    logic       hs_l_s;
    logic       vs_l_s;

    logic       de1_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       fs_r;
    logic       origin_r;
    logic       scr_hs_r;
    logic       scr_vs_r;
    logic       scr_de_r;
    logic [7:0] scr_pix_r;

    screen_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .step  (en),
        .clear (~en),
        .count (h_count_s),
        .phase (h_phase_s),
        .wrap  (h_wrap_s)
    );

    screen_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .step  (h_wrap_s),
        .clear (~en),
        .count (v_count_s),
        .phase (v_phase_s),
        .wrap  (v_wrap_s)
    );

    // Lead-stage raster qualifiers; all inactive while the raster is held.
    always_comb begin
        de_l_s = 1'b0;
        hs_l_s = 1'b0;
        vs_l_s = 1'b0;
        if (en) begin
            de_l_s = (h_phase_s == PH_ACT) && (v_phase_s == PH_ACT);
            hs_l_s = (h_phase_s == PH_SYNC);
            vs_l_s = (v_phase_s == PH_SYNC);
        end else begin
            de_l_s = 1'b0;
            hs_l_s = 1'b0;
            vs_l_s = 1'b0;
        end
    end

    // Stage 1; origin_r marks a lead position of (0,0) without a full counter compare.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de1_r    <= 1'b0;
            hsync_r  <= ~SYNC_POL;
            vsync_r  <= ~SYNC_POL;
            fs_r     <= 1'b0;
            origin_r <= 1'b1;
        end else begin
            de1_r    <= de_l_s;
            hsync_r  <= sync_level(hs_l_s, SYNC_POL);
            vsync_r  <= sync_level(vs_l_s, SYNC_POL);
            fs_r     <= de_l_s && origin_r;
            origin_r <= en ? v_wrap_s : 1'b1;
        end
    end

    // Stage 2: panel outputs aligned with the source's registered pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scr_hs_r  <= ~SYNC_POL;
            scr_vs_r  <= ~SYNC_POL;
            scr_de_r  <= 1'b0;
            scr_pix_r <= BLACK_LEVEL;
        end else begin
            scr_hs_r  <= hsync_r;
            scr_vs_r  <= vsync_r;
            scr_de_r  <= de1_r;
            scr_pix_r <= de1_r ? pix_val : BLACK_LEVEL;
        end
    end

    assign pf_pix_row  = v_count_s;
    assign pf_pix_col  = h_count_s;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = fs_r;
    assign scr_hs      = scr_hs_r;
    assign scr_vs      = scr_vs_r;
    assign scr_de      = scr_de_r;
    assign scr_pix     = scr_pix_r;

endmodule

// File: tb/tb_screen_timing_gen.sv
// Directed bench for screen_timing_gen: full-width lines, shortened frame height.
module tb_screen_timing_gen;

    localparam int V_ACT   = 6;
    localparam int V_FPN   = 1;
    localparam int V_SYN   = 2;
    localparam int V_BPN   = 1;
    localparam int LINE    = 994;
    localparam int FRAME   = 9940;   // 10 lines of 994
    localparam int LIMIT   = 12000;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [7:0] pix_val;
    logic [9:0] pf_pix_row;
    logic [9:0] pf_pix_col;
    logic       hsync, vsync, scr_hs, scr_vs, scr_de, frame_start;
    logic [7:0] scr_pix;

    int checks;
    int errors;

    screen_timing_gen #(
        .H_ACTIVE (834), .H_FP (16), .H_SYNC (64), .H_BP (80),
        .V_ACTIVE (V_ACT), .V_FP (V_FPN), .V_SYNC (V_SYN), .V_BP (V_BPN),
        .SYNC_POL (1'b1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .pix_val     (pix_val),
        .pf_pix_row  (pf_pix_row),
        .pf_pix_col  (pf_pix_col),
        .hsync       (hsync),
        .vsync       (vsync),
        .scr_hs      (scr_hs),
        .scr_vs      (scr_vs),
        .scr_de      (scr_de),
        .scr_pix     (scr_pix),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Pixel source model: registered column low byte.
    always @(posedge clk) pix_val <= pf_pix_col[7:0];

    task automatic wait_pf(input logic [9:0] row, input logic [9:0] col);
        int n;
        n = 0;
        while (!(pf_pix_row == row && pf_pix_col == col) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL wait_pf: pf=(%0d,%0d) never reached (%0d,%0d)", pf_pix_row, pf_pix_col, row, col);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        en   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pf_pix_row, pf_pix_col, hsync, vsync, scr_hs, scr_vs, scr_de, scr_pix, frame_start} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state: got row=%0d col=%0d hs=%b vs=%b shs=%b svs=%b de=%b pix=%0d fs=%b required all zero",
                     pf_pix_row, pf_pix_col, hsync, vsync, scr_hs, scr_vs, scr_de, scr_pix, frame_start);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (pf_pix_row !== 10'd0 || pf_pix_col !== 10'd0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL release_c0: pf=(%0d,%0d) fs=%b required (0,0) fs=0", pf_pix_row, pf_pix_col, frame_start);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || hsync !== 1'b0 || vsync !== 1'b0 || pf_pix_col !== 10'd1 || scr_de !== 1'b0) begin
            errors++;
            $display("FAIL release_c1: fs=%b hs=%b vs=%b col=%0d de=%b required 1 0 0 1 0",
                     frame_start, hsync, vsync, pf_pix_col, scr_de);
        end
        @(negedge clk);
        checks++;
        if (scr_de !== 1'b1 || scr_pix !== 8'd0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL release_c2: de=%b pix=%0d fs=%b required 1 0 0", scr_de, scr_pix, frame_start);
        end
        @(negedge clk);
        checks++;
        if (scr_pix !== 8'd1) begin
            errors++;
            $display("FAIL release_c3: pix=%0d required 1", scr_pix);
        end
    endtask

    task automatic test_lines;
        int de_cnt, hs_cnt, rise_col, pix_bad, rise_cyc, prev_rise, cyc;
        logic prev_hs;
        logic [9:0] d;
        logic [7:0] exp_pix;
        logic exp_de;
        wait_pf(10'd1, 10'd0);
        cyc = 0;
        prev_rise = -1;
        prev_hs = scr_hs;
        for (int ln = 0; ln < 3; ln++) begin
            de_cnt = 0; hs_cnt = 0; rise_col = -1; pix_bad = 0; rise_cyc = -1;
            for (int i = 0; i < LINE; i++) begin
                d       = pf_pix_col - 10'd2;
                exp_de  = (pf_pix_col >= 10'd2) && (pf_pix_col <= 10'd835);
                exp_pix = exp_de ? d[7:0] : 8'd0;
                if (scr_de !== exp_de || scr_pix !== exp_pix) pix_bad++;
                if (scr_de) de_cnt++;
                if (scr_hs) hs_cnt++;
                if (scr_hs && !prev_hs) begin
                    rise_col = int'(pf_pix_col);
                    rise_cyc = cyc;
                end
                prev_hs = scr_hs;
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (de_cnt != 834) begin errors++; $display("FAIL line%0d_de_count: got %0d required 834", ln, de_cnt); end
            checks++;
            if (hs_cnt != 64) begin errors++; $display("FAIL line%0d_hs_count: got %0d required 64", ln, hs_cnt); end
            checks++;
            if (rise_col != 852) begin errors++; $display("FAIL line%0d_hs_start: pf col %0d required 852", ln, rise_col); end
            checks++;
            if (pix_bad != 0) begin errors++; $display("FAIL line%0d_pixels: %0d bad cycles required 0", ln, pix_bad); end
            if (prev_rise >= 0) begin
                checks++;
                if (rise_cyc - prev_rise != LINE) begin
                    errors++;
                    $display("FAIL line%0d_hs_period: got %0d required %0d", ln, rise_cyc - prev_rise, LINE);
                end
            end
            prev_rise = rise_cyc;
        end
    endtask

    task automatic test_frames;
        int n, cyc, vs_hi, vs_rises, first_vs, second_vs, de_rises, fs_cnt, first_fs, last_fs;
        int rise_row, rise_col;
        logic prev_vs, prev_de;
        n = 0;
        while (frame_start !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin errors++; $display("FAIL frame_wait: no frame_start seen"); end
        cyc = 0; vs_hi = 0; vs_rises = 0; first_vs = -1; second_vs = -1;
        de_rises = 0; fs_cnt = 0; first_fs = -1; last_fs = -1; rise_row = -1; rise_col = -1;
        prev_vs = vsync;
        prev_de = scr_de;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            cyc++;
            if (vsync) vs_hi++;
            if (vsync && !prev_vs) begin
                vs_rises++;
                if (vs_rises == 1) begin
                    first_vs = cyc; rise_row = int'(pf_pix_row); rise_col = int'(pf_pix_col);
                end else begin
                    second_vs = cyc;
                end
            end
            if (scr_de && !prev_de) de_rises++;
            if (frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = cyc;
                last_fs = cyc;
            end
            prev_vs = vsync;
            prev_de = scr_de;
        end
        checks++;
        if (vs_hi != 2 * 2 * LINE) begin errors++; $display("FAIL vsync_width: got %0d required %0d", vs_hi, 4 * LINE); end
        checks++;
        if (vs_rises != 2) begin errors++; $display("FAIL vsync_edges: got %0d required 2", vs_rises); end
        checks++;
        if (rise_row != 7 || rise_col != 1) begin
            errors++; $display("FAIL vsync_start: pf=(%0d,%0d) required (7,1)", rise_row, rise_col);
        end
        checks++;
        if (second_vs - first_vs != FRAME) begin
            errors++; $display("FAIL vsync_period: got %0d required %0d", second_vs - first_vs, FRAME);
        end
        checks++;
        if (de_rises != 2 * V_ACT) begin errors++; $display("FAIL de_lines: got %0d required %0d", de_rises, 2 * V_ACT); end
        checks++;
        if (fs_cnt != 2 || last_fs - first_fs != FRAME) begin
            errors++; $display("FAIL frame_start_period: count %0d spacing %0d required 2 and %0d", fs_cnt, last_fs - first_fs, FRAME);
        end
    endtask

    task automatic test_wrap;
        wait_pf(10'd9, 10'd993);
        @(negedge clk);
        checks++;
        if (pf_pix_row !== 10'd0 || pf_pix_col !== 10'd0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL wrap_pf: pf=(%0d,%0d) fs=%b required (0,0) fs=0", pf_pix_row, pf_pix_col, frame_start);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap_fs: got %b required 1", frame_start); end
    endtask

    task automatic test_en_drop(input logic [9:0] row, input logic [9:0] col);
        wait_pf(row, col);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (pf_pix_row !== 10'd0 || pf_pix_col !== 10'd0 || hsync !== 1'b0 || vsync !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL en_low_stage1 @col%0d: pf=(%0d,%0d) hs=%b vs=%b fs=%b required (0,0) 0 0 0",
                     col, pf_pix_row, pf_pix_col, hsync, vsync, frame_start);
        end
        @(negedge clk);
        checks++;
        if (scr_de !== 1'b0 || scr_hs !== 1'b0 || scr_vs !== 1'b0 || scr_pix !== 8'd0) begin
            errors++;
            $display("FAIL en_low_stage2 @col%0d: de=%b hs=%b vs=%b pix=%0d required blank", col, scr_de, scr_hs, scr_vs, scr_pix);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pf_pix_row !== 10'd0 || pf_pix_col !== 10'd0 || scr_de !== 1'b0) begin
            errors++; $display("FAIL en_low_hold: pf=(%0d,%0d) de=%b required (0,0) 0", pf_pix_row, pf_pix_col, scr_de);
        end
        en = 1'b1;
        #1;
        checks++;
        if (pf_pix_col !== 10'd0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL en_high_c0: col=%0d fs=%b required 0 0", pf_pix_col, frame_start);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || pf_pix_col !== 10'd1 || scr_de !== 1'b0) begin
            errors++; $display("FAIL en_high_c1: fs=%b col=%0d de=%b required 1 1 0", frame_start, pf_pix_col, scr_de);
        end
        @(negedge clk);
        checks++;
        if (scr_de !== 1'b1 || scr_pix !== 8'd0) begin
            errors++; $display("FAIL en_high_c2: de=%b pix=%0d required 1 0", scr_de, scr_pix);
        end
        @(negedge clk);
        checks++;
        if (scr_pix !== 8'd1) begin errors++; $display("FAIL en_high_c3: pix=%0d required 1", scr_pix); end
    endtask

    task automatic test_rst_pulse(input logic [9:0] row, input logic [9:0] col);
        wait_pf(row, col);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({pf_pix_row, pf_pix_col, hsync, vsync, scr_hs, scr_vs, scr_de, scr_pix, frame_start} !== 33'd0) begin
            errors++;
            $display("FAIL rst_pulse @(%0d,%0d): row=%0d col=%0d hs=%b vs=%b shs=%b svs=%b de=%b pix=%0d fs=%b required all zero",
                     row, col, pf_pix_row, pf_pix_col, hsync, vsync, scr_hs, scr_vs, scr_de, scr_pix, frame_start);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || pf_pix_col !== 10'd1) begin
            errors++; $display("FAIL rst_restart: fs=%b col=%0d required 1 1", frame_start, pf_pix_col);
        end
    endtask

    initial begin
        clk    = 1'b0;
        rstn   = 1'b0;
        en     = 1'b1;
        checks = 0;
        errors = 0;
        test_reset();
        test_lines();
        test_frames();
        test_wrap();
        test_en_drop(10'd5, 10'd500);
        test_en_drop(10'd5, 10'd900);
        test_rst_pulse(10'd3, 10'd300);
        test_rst_pulse(10'd7, 10'd880);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
